// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes: a 128-bit state is substituted in place, BYTES_PER_CYCLE
// bytes per cycle through shared forward S-box lanes, then handed off over valid/ready.
module aes_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    // state | meaning
    // IDLE  | waiting for a state; in_ready=1
    // RUN   | substituting pass cnt of NPASS in the work register
    // DONE  | result presented on out_data until out_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NPASS = 16 / BYTES_PER_CYCLE;
    localparam int CW = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("aes_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [127:0]   work, work_next, out_q;

    // Byte k lives at work[127-8k -: 8]; this pass covers k = cnt*BPC .. cnt*BPC+BPC-1.
    always_comb begin
        int pos;
        pos       = 0;
        work_next = work;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            pos = 8 * (15 - (int'(cnt) * BYTES_PER_CYCLE + j));
            work_next[pos +: 8] = sbox(work[pos +: 8]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            work  <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work <= in_data;
                    cnt  <= '0;
                end
                RUN: begin
                    work <= work_next;
                    // out_data is only loaded on the way into DONE so it never shows a partial state.
                    if (cnt == LAST) out_q <= work_next;
                    else             cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: directed vector table, handshake corner sequences,
// BPC sweep and a randomized run against an S-box computed from GF(2^8) arithmetic.
module tb_aes_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    always #5 clk = ~clk;

    aes_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Sweep instances: index 0..3 -> BPC 1, 2, 8, 16
    logic         sw_in_valid [4];
    logic         sw_in_ready [4];
    logic [127:0] sw_in_data;
    logic         sw_out_valid [4];
    logic         sw_out_ready [4];
    logic [127:0] sw_out_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        aes_sub_bytes_iter #(.BYTES_PER_CYCLE(B)) u_sw (
            .clk(clk), .rst(rst),
            .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]), .in_data(sw_in_data),
            .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready[g]), .out_data(sw_out_data[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;
    logic [7:0] ref_sbox [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs [5];

    always @(negedge clk) if (in_ready && out_valid) overlap++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_sbox[s[127-8*k -: 8]];
        return r;
    endfunction

    task automatic run_vec(input logic [127:0] din, output logic [127:0] dout, output int lat);
        int w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        in_data  = din;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin step(); lat++; end
        dout      = out_data;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [127:0] got, captured, rd;
    int           lat, w, rcv, cyc, drv_timeout;
    bit           stable, acc, rv;
    logic [127:0] exp_q [$];
    int           sw_lat [4];
    logic [127:0] sw_got [4];
    int           sw_lat_exp [4] = '{16, 8, 2, 1};

    initial begin
        vecs[0] = '{128'h193DE3BEA0F4E22B9AC68D2AE9F84808, 128'hD42711AEE0BF98F1B8B45DE51E415230};
        vecs[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
        vecs[2] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h16161616161616161616161616161616};
        vecs[3] = '{128'h53535353535353535353535353535353, 128'hEDEDEDEDEDEDEDEDEDEDEDEDEDEDEDED};
        vecs[4] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h637C777BF26B6FC53001672BFED7AB76};
        for (int i = 0; i < 4; i++) begin sw_in_valid[i] = 1'b0; sw_out_ready[i] = 1'b0; end
        sw_in_data = '0;
        build_sbox();

        step(); step();
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data",  out_data,        128'd0);
        rst = 1'b0;
        step();

        // Directed table, BPC=4: expect data and 4-cycle latency.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].din, got, lat);
            check($sformatf("vec%0d_data", i), got, vecs[i].dout);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'd4);
        end

        // Backpressure in DONE, with in_data/in_valid wiggling while busy.
        in_data = vecs[0].din; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 128'hDEADBEEF;
        w = 0;
        while (!out_valid && w < 50) begin step(); w++; end
        captured = out_data;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[1].din;
            step();
            if (!out_valid || out_data !== captured || in_ready) stable = 1'b0;
        end
        check("bp_data",   captured,       vecs[0].dout);
        check("bp_stable", 128'(stable),   128'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_in_ready_after",  128'(in_ready),  128'd1);
        check("bp_out_valid_after", 128'(out_valid), 128'd0);
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin step(); w++; end
        check("bp_next_data", out_data, vecs[1].dout);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Async reset two cycles into RUN, asserted between clock edges.
        in_data = vecs[2].din; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        check("ar_in_ready",  128'(in_ready),  128'd1);
        check("ar_out_valid", 128'(out_valid), 128'd0);
        check("ar_out_data",  out_data,        128'd0);
        rst = 1'b0;
        step();
        run_vec(vecs[0].din, got, lat);
        check("ar_redo_data", got, vecs[0].dout);
        check("ar_redo_lat",  128'(lat), 128'd4);

        // Parameter sweep.
        sw_in_data = vecs[0].din;
        for (int i = 0; i < 4; i++) begin sw_in_valid[i] = 1'b1; sw_lat[i] = 0; sw_got[i] = '0; end
        step();
        for (int i = 0; i < 4; i++) sw_in_valid[i] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            for (int i = 0; i < 4; i++)
                if (sw_out_valid[i] && sw_lat[i] == 0) begin sw_lat[i] = c; sw_got[i] = sw_out_data[i]; end
        end
        for (int i = 0; i < 4; i++) sw_out_ready[i] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            sw_out_ready[i] = 1'b0;
            check($sformatf("sweep%0d_data", i), sw_got[i], vecs[0].dout);
            check($sformatf("sweep%0d_lat", i), 128'(sw_lat[i]), 128'(sw_lat_exp[i]));
        end

        // Random states with random gaps and backpressure.
        rcv = 0; cyc = 0; drv_timeout = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [127:0] d;
                    repeat ($urandom_range(0, 3)) step();
                    d = {$urandom, $urandom, $urandom, $urandom};
                    in_data = d; in_valid = 1'b1; acc = 1'b0; w = 0;
                    while (!acc && w < 200) begin acc = in_ready; step(); w++; end
                    in_valid = 1'b0;
                    if (acc) exp_q.push_back(ref_sub(d));
                    else drv_timeout++;
                end
            end
            begin
                while (rcv < 1000 && cyc < 40000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    rv = out_valid;
                    rd = out_data;
                    step();
                    cyc++;
                    if (rv && out_ready) begin
                        rcv++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL rnd_extra: got %h expected no output", rd);
                        end else begin
                            check("rnd_data", rd, exp_q.pop_front());
                        end
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("rnd_count",    128'(rcv),          128'd1000);
        check("rnd_leftover", 128'(exp_q.size()), 128'd0);
        check("rnd_drv_stall", 128'(drv_timeout), 128'd0);
        check("no_overlap",   128'(overlap),      128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
